pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TRAP_VECTOR, 32'h0000_0180, PC value loaded on a misaligned register-jump target.
REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: JRControl, input, 1, jump-register request decoded from {ALUOp, Function}.
REQ-006 Port: Jump, input, 1, J-format jump request.
REQ-007 Port: Branch, input, 1, conditional-branch request.
REQ-008 Port: Zero, input, 1, ALU zero flag qualifying Branch.
REQ-009 Port: JumpAddr, input, 26, J-format target field.
REQ-010 Port: BranchOffset, input, 32, sign-extended branch immediate, in words.
REQ-011 Port: RegRs, input, 32, rs register value used as the jump-register target.
REQ-012 Port: Stall, input, 1, hold request; freezes the PC and FSM for the cycle.
REQ-013 Port: PC, output, 32, current instruction address (registered).
REQ-014 Port: PCplus4, output, 32, PC+4 (combinational from PC).
REQ-015 Port: Valid, output, 1, PC addresses a real instruction this cycle.
REQ-016 Port: Trap, output, 1, one-cycle pulse marking a misalignment redirect.
REQ-017 Port: TrapPC, output, 32, address of the faulting jump-register instruction (registered).
REQ-018 Port: RedirectCount, output, 16, count of taken control transfers (registered).

Function
REQ-019 The FSM SHALL have three states: BOOT, RUN and TRAP.
REQ-020 BOOT SHALL be entered on reset, SHALL hold Valid=0 and PC=RESET_PC, and SHALL go to RUN on the next edge where Stall=0.
REQ-021 In RUN with Stall=0, next PC SHALL use this priority order: JRControl, then Jump, then (Branch AND Zero), otherwise PCplus4.
REQ-022 The JR target SHALL be RegRs.
REQ-023 The jump target SHALL be {PCplus4[31:28], JumpAddr, 2'b00}.
REQ-024 The branch target SHALL be PCplus4 + (BranchOffset << 2), computed modulo 2^32 with overflow ignored.
REQ-025 PCplus4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-026 If JRControl=1 and RegRs[1:0]!=0 in RUN with Stall=0, the block SHALL:
- load PC=TRAP_VECTOR;
- capture TrapPC=PC;
- enter TRAP.
REQ-027 In TRAP, Trap SHALL be 1 and Valid SHALL be 0 for exactly one cycle; the FSM SHALL then return to RUN, with no other next-PC evaluation in that cycle.
REQ-028 Stall=1 SHALL hold PC, TrapPC, RedirectCount and the FSM state unchanged in every state.
REQ-029 If Stall=1 while in TRAP, Trap SHALL remain asserted until the first cycle with Stall=0.
REQ-030 Valid SHALL be 1 in RUN and 0 in BOOT and TRAP.
REQ-031 RedirectCount SHALL increment by 1 on each non-stalled RUN cycle that selects a JR, jump, taken-branch or trap target, and SHALL wrap from 16'hFFFF to 0.
REQ-032 A taken branch or jump whose target equals PCplus4 SHALL still count as a redirect.
REQ-033 Request inputs SHALL be ignored in BOOT and TRAP.

Reset
REQ-034 While rst_n=0, and immediately on its assertion, the block SHALL force:
- PC=RESET_PC;
- TrapPC=0;
- RedirectCount=0;
- state=BOOT, Valid=0, Trap=0.
REQ-035 Reset asserted mid-operation, including in TRAP or under Stall, SHALL discard all pending state.
REQ-036 Reset deassertion SHALL be synchronized externally; the block SHALL take no action before the first clk edge after rst_n rises.

Structure
REQ-037 The FSM state encoding, the RESET_PC and TRAP_VECTOR defaults, and the 16-bit counter width SHALL live in the shared package pc_pkg.
REQ-038 Target computation (PCplus4, branch target, jump target, priority mux) SHALL be the combinational sub-module pc_target_calc.
REQ-039 The FSM and all registers SHALL reside in pc_sequencer.

Verification
REQ-040 Reset release with Stall=0: cycle 0 PC=0 and Valid=0; cycle 1 PC=0 and Valid=1; cycle 2 PC=4.
REQ-041 Branch=1, Zero=1, BranchOffset=32'hFFFF_FFFF at PC=0x100 -> next PC=0x100 and RedirectCount+1; with Zero=0 -> next PC=0x104.
REQ-042 JRControl=1, Jump=1, RegRs=0x2000, JumpAddr=0x0000040 at PC=0x3000_0010 -> next PC=0x2000; with JRControl=0 -> next PC=0x3000_0100.
REQ-043 JRControl=1, RegRs=0x2002 at PC=0x40 -> next PC=0x180, TrapPC=0x40, Trap=1 and Valid=0 for one cycle, then PC=0x184.
REQ-044 Stall=1 for 3 cycles during TRAP, then a mid-run rst_n pulse:
- during the stall, PC, Trap and the count SHALL stay frozen;
- on the rst_n pulse, PC=0 immediately, asynchronous to clk.
REQ-045 PC=32'hFFFF_FFFC with no request -> next PC=0; RedirectCount=16'hFFFF plus a taken jump -> RedirectCount=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM encoding, default vectors, counter width.
// No logic here; latency and backpressure are properties of the modules that import it.
// Backpressure: not applicable.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0180;

    localparam int unsigned          CNT_W   = 16;
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC selection: PC+4, branch, jump and register-jump targets under fixed priority.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to load the result.
module pc_target_calc #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
    input  logic [31:0] pc,
    input  logic        jr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [25:0] jump_addr,
    input  logic [31:0] branch_offset,
    input  logic [31:0] reg_rs,
    output logic [31:0] pcplus4,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misaligned
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign pcplus4       = pc + 32'd4;
    assign branch_target = pcplus4 + (branch_offset << 2);
    assign jump_target   = {pcplus4[31:28], jump_addr, 2'b00};
    assign misaligned    = jr && (reg_rs[1:0] != 2'b00);

    // A selected transfer counts as a redirect even when it lands on PC+4.
    always_comb begin
        next_pc  = pcplus4;
        redirect = 1'b0;
        if (jr) begin
            redirect = 1'b1;
            next_pc  = misaligned ? TRAP_VECTOR : reg_rs;
        end else if (jump) begin
            redirect = 1'b1;
            next_pc  = jump_target;
        end else if (branch && zero) begin
            redirect = 1'b1;
            next_pc  = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with boot, run and misaligned-jump trap states.
// Latency: one cycle from request to new PC; TRAP and BOOT each occupy one non-stalled cycle.
// Backpressure: Stall freezes PC, TrapPC, RedirectCount and FSM state for the cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             JRControl,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [25:0]      JumpAddr,
    input  logic [31:0]      BranchOffset,
    input  logic [31:0]      RegRs,
    input  logic             Stall,
    output logic [31:0]      PC,
    output logic [31:0]      PCplus4,
    output logic             Valid,
    output logic             Trap,
    output logic [31:0]      TrapPC,
    output logic [CNT_W-1:0] RedirectCount
);

    pc_state_t   state;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;

    pc_target_calc #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_calc (
        .pc            (PC),
        .jr            (JRControl),
        .jump          (Jump),
        .branch        (Branch),
        .zero          (Zero),
        .jump_addr     (JumpAddr),
        .branch_offset (BranchOffset),
        .reg_rs        (RegRs),
        .pcplus4       (PCplus4),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    // BOOT and TRAP hold PC so the instruction at that address is issued once RUN begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            PC            <= RESET_PC;
            TrapPC        <= '0;
            RedirectCount <= '0;
            Valid         <= 1'b0;
            Trap          <= 1'b0;
        end else if (!Stall) begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    Valid <= 1'b1;
                end
                ST_RUN: begin
                    PC <= next_pc;
                    if (redirect) begin
                        RedirectCount <= RedirectCount + CNT_ONE;
                    end
                    if (misaligned) begin
                        TrapPC <= PC;
                        state  <= ST_TRAP;
                        Valid  <= 1'b0;
                        Trap   <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    state <= ST_RUN;
                    Valid <= 1'b1;
                    Trap  <= 1'b0;
                end
                default: begin
                    state <= ST_BOOT;
                    Valid <= 1'b0;
                    Trap  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for next-PC selection plus hand sequences
// for boot, trap, stall, asynchronous reset and counter wrap.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        JRControl, Jump, Branch, Zero, Stall;
    logic [25:0] JumpAddr;
    logic [31:0] BranchOffset, RegRs;
    logic [31:0] PC, PCplus4, TrapPC;
    logic        Valid, Trap;
    logic [15:0] RedirectCount;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .JRControl     (JRControl),
        .Jump          (Jump),
        .Branch        (Branch),
        .Zero          (Zero),
        .JumpAddr      (JumpAddr),
        .BranchOffset  (BranchOffset),
        .RegRs         (RegRs),
        .Stall         (Stall),
        .PC            (PC),
        .PCplus4       (PCplus4),
        .Valid         (Valid),
        .Trap          (Trap),
        .TrapPC        (TrapPC),
        .RedirectCount (RedirectCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic        jr, jump, branch, zero;
        logic [25:0] jaddr;
        logic [31:0] boff;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_redir;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        JRControl    = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        JumpAddr     = '0;
        BranchOffset = '0;
        RegRs        = '0;
    endtask

    // Reaches an arbitrary aligned PC through a register jump (one redirect).
    task automatic goto_pc(input logic [31:0] target);
        clear_req();
        JRControl = 1'b1;
        RegRs     = target;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("goto_pc", PC, target);
        clear_req();
    endtask

    initial begin
        vecs[0] = '{"br_taken_neg1",  32'h0000_0100, 0, 0, 1, 1, 26'h0,      32'hFFFF_FFFF, 32'h0, 32'h0000_0100, 1};
        vecs[1] = '{"br_not_taken",   32'h0000_0100, 0, 0, 1, 0, 26'h0,      32'hFFFF_FFFF, 32'h0, 32'h0000_0104, 0};
        vecs[2] = '{"jr_over_jump",   32'h3000_0010, 1, 1, 0, 0, 26'h40,     32'h0,         32'h2000, 32'h0000_2000, 1};
        vecs[3] = '{"jump_region",    32'h3000_0010, 0, 1, 0, 0, 26'h40,     32'h0,         32'h0, 32'h3000_0100, 1};
        vecs[4] = '{"pc4_wrap",       32'hFFFF_FFFC, 0, 0, 0, 0, 26'h0,      32'h0,         32'h0, 32'h0000_0000, 0};
        vecs[5] = '{"jump_to_pc4",    32'h0000_1000, 0, 1, 0, 0, 26'h401,    32'h0,         32'h0, 32'h0000_1004, 1};
        vecs[6] = '{"br_off_zero",    32'h0000_0200, 0, 0, 1, 1, 26'h0,      32'h0,         32'h0, 32'h0000_0204, 1};
        vecs[7] = '{"jump_over_br",   32'h0000_0500, 0, 1, 1, 1, 26'h10,     32'h5,         32'h0, 32'h0000_0040, 1};
        vecs[8] = '{"br_overflow",    32'hFFFF_FFF0, 0, 0, 1, 1, 26'h0,      32'h4,         32'h0, 32'h0000_0004, 1};
        vecs[9] = '{"zero_no_branch", 32'h0000_0300, 0, 0, 0, 1, 26'h0,      32'h7,         32'h0, 32'h0000_0304, 0};

        clear_req();
        Stall   = 1'b0;
        rst_n   = 1'b0;
        exp_cnt = '0;

        // Reset values, then boot timing.
        step();
        step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'b0, Valid}, 32'h0);
        chk("rst_trap", {31'b0, Trap}, 32'h0);
        chk("rst_trappc", TrapPC, 32'h0);
        chk("rst_cnt", {16'b0, RedirectCount}, 32'h0);
        rst_n = 1'b1;
        chk("boot_c0_pc", PC, 32'h0);
        chk("boot_c0_valid", {31'b0, Valid}, 32'h0);
        step();
        chk("boot_c1_pc", PC, 32'h0);
        chk("boot_c1_valid", {31'b0, Valid}, 32'h1);
        step();
        chk("boot_c2_pc", PC, 32'h4);
        chk("boot_c2_pc4", PCplus4, 32'h8);

        for (int i = 0; i < 10; i++) begin
            goto_pc(vecs[i].start_pc);
            JRControl    = vecs[i].jr;
            Jump         = vecs[i].jump;
            Branch       = vecs[i].branch;
            Zero         = vecs[i].zero;
            JumpAddr     = vecs[i].jaddr;
            BranchOffset = vecs[i].boff;
            RegRs        = vecs[i].rs;
            step();
            if (vecs[i].exp_redir) exp_cnt = exp_cnt + 16'd1;
            chk({vecs[i].name, "_pc"}, PC, vecs[i].exp_pc);
            chk({vecs[i].name, "_cnt"}, {16'b0, RedirectCount}, {16'b0, exp_cnt});
            chk({vecs[i].name, "_valid"}, {31'b0, Valid}, 32'h1);
            clear_req();
        end

        // Misaligned register jump: one trap cycle, requests ignored, then resume at vector.
        goto_pc(32'h0000_0040);
        JRControl = 1'b1;
        RegRs     = 32'h0000_2002;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("trap_pc", PC, 32'h0000_0180);
        chk("trap_trappc", TrapPC, 32'h0000_0040);
        chk("trap_flag", {31'b0, Trap}, 32'h1);
        chk("trap_valid", {31'b0, Valid}, 32'h0);
        chk("trap_cnt", {16'b0, RedirectCount}, {16'b0, exp_cnt});
        clear_req();
        Jump     = 1'b1;
        JumpAddr = 26'h999;
        step();
        chk("post_trap_pc", PC, 32'h0000_0180);
        chk("post_trap_flag", {31'b0, Trap}, 32'h0);
        chk("post_trap_valid", {31'b0, Valid}, 32'h1);
        chk("post_trap_cnt", {16'b0, RedirectCount}, {16'b0, exp_cnt});
        clear_req();
        step();
        chk("resume_pc", PC, 32'h0000_0184);

        // Stall while in TRAP freezes everything.
        goto_pc(32'h0000_0080);
        JRControl = 1'b1;
        RegRs     = 32'h0000_0003;
        step();
        exp_cnt = exp_cnt + 16'd1;
        clear_req();
        Stall = 1'b1;
        Jump  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'h0000_0180);
            chk("stall_trap", {31'b0, Trap}, 32'h1);
            chk("stall_valid", {31'b0, Valid}, 32'h0);
            chk("stall_trappc", TrapPC, 32'h0000_0080);
            chk("stall_cnt", {16'b0, RedirectCount}, {16'b0, exp_cnt});
        end

        // Asynchronous reset mid-trap, no clock edge in between.
        rst_n = 1'b0;
        #1;
        chk("arst_pc", PC, 32'h0);
        chk("arst_trap", {31'b0, Trap}, 32'h0);
        chk("arst_trappc", TrapPC, 32'h0);
        chk("arst_cnt", {16'b0, RedirectCount}, 32'h0);
        exp_cnt = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("boot_stall_valid", {31'b0, Valid}, 32'h0);
        chk("boot_stall_pc", PC, 32'h0);
        Stall = 1'b0;
        clear_req();
        step();
        chk("boot_run_valid", {31'b0, Valid}, 32'h1);

        // Counter wrap: a jump every cycle.
        Jump     = 1'b1;
        JumpAddr = 26'h0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt_ffff", {16'b0, RedirectCount}, 32'h0000_FFFF);
        chk("cnt_ffff_pc", PC, 32'h0);
        step();
        chk("cnt_wrap", {16'b0, RedirectCount}, 32'h0);
        clear_req();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
